// File: rtl/mips_branch_pkg.sv
// Shared definitions for the ID-stage branch resolution logic: FSM encoding,
// the hard-wired zero register and the branch opcodes.
package mips_branch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } br_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle between the ID stage / hazard fields and the branch resolve unit.
// master = pipeline side driving operands, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int AW    = 32,
  parameter int RW    = 5,
  parameter int STATW = 32
) ();
  logic             id_beq;
  logic             id_bne;
  logic [RW-1:0]    id_rs;
  logic [RW-1:0]    id_rt;
  logic [AW-1:0]    id_target;
  logic             cmp_equal;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [RW-1:0]    ex_rd;
  logic             mem_mem_read;
  logic [RW-1:0]    mem_rd;
  logic             pipe_hold;
  logic             stall;
  logic             idex_bubble;
  logic             pc_src;
  logic             flush_ifid;
  logic [AW-1:0]    branch_target;
  logic [STATW-1:0] stat_branches;
  logic [STATW-1:0] stat_taken;
  logic [STATW-1:0] stat_stalls;

  modport master (
    output id_beq, id_bne, id_rs, id_rt, id_target, cmp_equal,
           ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd, pipe_hold,
    input  stall, idex_bubble, pc_src, flush_ifid, branch_target,
           stat_branches, stat_taken, stat_stalls
  );

  modport slave (
    input  id_beq, id_bne, id_rs, id_rt, id_target, cmp_equal,
           ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd, pipe_hold,
    output stall, idex_bubble, pc_src, flush_ifid, branch_target,
           stat_branches, stat_taken, stat_stalls
  );
endinterface

// File: rtl/branch_hazard_detect.sv
// Combinational count of cycles a branch must wait for its operands to leave
// EX/MEM before the ID-stage comparator sees valid values.
module branch_hazard_detect
  import mips_branch_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          id_rs_i,
  input  logic          id_rt_i,
  input  logic          ex_reg_write_i,
  input  logic          ex_mem_read_i,
  input  logic [RW-1:0] ex_rd_i,
  input  logic          mem_mem_read_i,
  input  logic [RW-1:0] mem_rd_i,
  input  logic [RW-1:0] rs_i,
  input  logic [RW-1:0] rt_i,
  output logic [1:0]    wait_n_o
);

  function automatic logic reg_match(input logic [RW-1:0] r,
                                     input logic [RW-1:0] rs,
                                     input logic [RW-1:0] rt);
    return (r != RW'(REG_ZERO)) && ((r == rs) || (r == rt));
  endfunction

  // A load in EX needs two cycles (EX->MEM->WB); ALU results and MEM loads one.
  always_comb begin
    wait_n_o = 2'd0;
    if (ex_mem_read_i && reg_match(ex_rd_i, rs_i, rt_i)) begin
      wait_n_o = 2'd2;
    end else if (ex_reg_write_i && reg_match(ex_rd_i, rs_i, rt_i)) begin
      wait_n_o = 2'd1;
    end else if (mem_mem_read_i && reg_match(mem_rd_i, rs_i, rt_i)) begin
      wait_n_o = 2'd1;
    end else begin
      wait_n_o = 2'd0;
    end
    // id_rs_i/id_rt_i are the branch qualifiers; a non-branch never waits
    if (!(id_rs_i | id_rt_i)) begin
      wait_n_o = 2'd0;
    end else begin
      wait_n_o = wait_n_o;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage BEQ/BNE resolution: stalls on in-flight operands, then drives
// pc_src/flush_ifid/branch_target. Optional counters under `BRANCH_STATS_EN.
module branch_resolve_unit
  import mips_branch_pkg::*;
#(
  parameter int AW    = 32,
  parameter int RW    = 5,
  parameter int STATW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus
);

  br_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] wait_n_s;
  logic       br_s, taken_s, active_s, stall_s, resolve_s;

  assign br_s     = bus.id_beq | bus.id_bne;
  assign taken_s  = bus.id_beq ? bus.cmp_equal : (bus.id_bne & ~bus.cmp_equal);
  assign active_s = rst_n & ~bus.pipe_hold;

  branch_hazard_detect #(.RW(RW)) u_hazard (
    .id_rs_i        (bus.id_beq),
    .id_rt_i        (bus.id_bne),
    .ex_reg_write_i (bus.ex_reg_write),
    .ex_mem_read_i  (bus.ex_mem_read),
    .ex_rd_i        (bus.ex_rd),
    .mem_mem_read_i (bus.mem_mem_read),
    .mem_rd_i       (bus.mem_rd),
    .rs_i           (bus.id_rs),
    .rt_i           (bus.id_rt),
    .wait_n_o       (wait_n_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: cnt counts stall cycles still owed after the current one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.pipe_hold) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (br_s && (wait_n_s != 2'd0)) begin
            cnt_d   = wait_n_s - 2'd1;
            state_d = (wait_n_s == 2'd1) ? ST_RESOLVE : ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!br_s) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d   = cnt_q - 2'd1;
            state_d = (cnt_q <= 2'd1) ? ST_RESOLVE : ST_WAIT;
          end
        end
        ST_RESOLVE: begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Output decode before reset/hold gating
  always_comb begin
    stall_s   = 1'b0;
    resolve_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_s) begin
          stall_s   = (wait_n_s != 2'd0);
          resolve_s = (wait_n_s == 2'd0);
        end else begin
          stall_s = 1'b0;
        end
      end
      ST_WAIT:    stall_s   = br_s;
      ST_RESOLVE: resolve_s = br_s;
      default: begin
        stall_s   = 1'b0;
        resolve_s = 1'b0;
      end
    endcase
  end

  assign bus.stall         = active_s & stall_s;
  assign bus.idex_bubble   = active_s & stall_s;
  assign bus.pc_src        = active_s & resolve_s & taken_s;
  assign bus.flush_ifid    = active_s & resolve_s & taken_s;
  assign bus.branch_target = bus.pc_src ? bus.id_target : {AW{1'b0}};

`ifdef BRANCH_STATS_EN
  logic [STATW-1:0] stat_br_q, stat_tk_q, stat_st_q;

  // Statistics counters, frozen with the rest of the unit under pipe_hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_br_q <= {STATW{1'b0}};
      stat_tk_q <= {STATW{1'b0}};
      stat_st_q <= {STATW{1'b0}};
    end else if (active_s) begin
      stat_br_q <= stat_br_q + STATW'(resolve_s);
      stat_tk_q <= stat_tk_q + STATW'(resolve_s & taken_s);
      stat_st_q <= stat_st_q + STATW'(stall_s);
    end else begin
      stat_br_q <= stat_br_q;
      stat_tk_q <= stat_tk_q;
      stat_st_q <= stat_st_q;
    end
  end

  assign bus.stat_branches = rst_n ? stat_br_q : {STATW{1'b0}};
  assign bus.stat_taken    = rst_n ? stat_tk_q : {STATW{1'b0}};
  assign bus.stat_stalls   = rst_n ? stat_st_q : {STATW{1'b0}};
`else
  assign bus.stat_branches = {STATW{1'b0}};
  assign bus.stat_taken    = {STATW{1'b0}};
  assign bus.stat_stalls   = {STATW{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_branch_resolve_unit;
  localparam int AW = 32, RW = 5, STATW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.AW(AW), .RW(RW), .STATW(STATW)) bus ();
  branch_resolve_unit #(.AW(AW), .RW(RW), .STATW(STATW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: busy = branch waiting, left = stall cycles still owed
  bit               m_busy = 1'b0, nx_busy;
  int               m_left = 0, nx_left;
  logic [STATW-1:0] m_nb = '0, m_nt = '0, m_ns = '0, nx_nb, nx_nt, nx_ns;
  logic             e_stall, e_pc;
  logic [AW-1:0]    e_tgt;
  logic [STATW-1:0] e_nb, e_nt, e_ns;

  function automatic bit hz(input logic [RW-1:0] r);
    return (r != 0) && (r == bus.id_rs || r == bus.id_rt);
  endfunction

  function automatic int n_req();
    if (bus.ex_mem_read && hz(bus.ex_rd)) return 2;
    if (bus.ex_reg_write && hz(bus.ex_rd)) return 1;
    if (bus.mem_mem_read && hz(bus.mem_rd)) return 1;
    return 0;
  endfunction

  task automatic model_eval();
    bit br, tk, res;
    int n;
    br = bus.id_beq | bus.id_bne;
    tk = bus.id_beq ? bus.cmp_equal : (bus.id_bne & ~bus.cmp_equal);
    e_stall = 0; e_pc = 0; res = 0;
    nx_busy = m_busy; nx_left = m_left; nx_nb = m_nb; nx_nt = m_nt; nx_ns = m_ns;
    if (!rst_n) begin
      nx_busy = 0; nx_left = 0; nx_nb = '0; nx_nt = '0; nx_ns = '0;
    end else if (!bus.pipe_hold) begin
      if (!m_busy) begin
        if (br) begin
          n = n_req();
          if (n == 0) res = 1;
          else begin e_stall = 1; nx_busy = 1; nx_left = n - 1; end
        end
      end else if (!br) nx_busy = 0;
      else if (m_left > 0) begin e_stall = 1; nx_left = m_left - 1; end
      else begin res = 1; nx_busy = 0; end
      e_pc = res & tk;
      nx_nb = m_nb + STATW'(res);
      nx_nt = m_nt + STATW'(res & tk);
      nx_ns = m_ns + STATW'(e_stall);
    end
    e_tgt = e_pc ? bus.id_target : '0;
`ifdef BRANCH_STATS_EN
    e_nb = rst_n ? m_nb : '0; e_nt = rst_n ? m_nt : '0; e_ns = rst_n ? m_ns : '0;
`else
    e_nb = '0; e_nt = '0; e_ns = '0;
`endif
  endtask

  task automatic cyc();
    model_eval();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    m_busy = nx_busy; m_left = nx_left; m_nb = nx_nb; m_nt = nx_nt; m_ns = nx_ns;
    #1;
  endtask

  task automatic clr_all();
    bus.id_beq = 0; bus.id_bne = 0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_target = '0; bus.cmp_equal = 0; bus.ex_reg_write = 0; bus.ex_mem_read = 0;
    bus.ex_rd = '0; bus.mem_mem_read = 0; bus.mem_rd = '0; bus.pipe_hold = 0;
  endtask

  task automatic set_br(input bit beq, input bit bne, input int rs, input int rt,
                        input bit eq, input logic [AW-1:0] tgt);
    bus.id_beq = beq; bus.id_bne = bne; bus.id_rs = RW'(rs); bus.id_rt = RW'(rt);
    bus.cmp_equal = eq; bus.id_target = tgt;
  endtask

  task automatic apply_reset();
    clr_all(); rst_n = 0; cyc(); adv(); rst_n = 1;
  endtask

  task automatic test_reset();
    clr_all(); rst_n = 0;
    set_br(1, 0, 3, 7, 1, 32'h0000_1000);
    bus.ex_mem_read = 1; bus.ex_rd = 5'd7;
    cyc();
    n_checks++;
    if ({bus.stall, bus.idex_bubble, bus.pc_src, bus.flush_ifid} !== 4'b0000 || bus.branch_target !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got stall/bub/pc/fl=%b%b%b%b tgt=%h, want 0000 tgt=0",
        bus.stall, bus.idex_bubble, bus.pc_src, bus.flush_ifid, bus.branch_target);
    end
    n_checks++;
    if (bus.stat_branches !== '0 || bus.stat_taken !== '0 || bus.stat_stalls !== '0) begin
      n_errors++; $display("FAIL reset_stats: got %0d/%0d/%0d, want 0/0/0",
        bus.stat_branches, bus.stat_taken, bus.stat_stalls);
    end
    adv(); rst_n = 1; clr_all();
  endtask

  task automatic test_no_hazard();
    set_br(1, 0, 3, 4, 1, 32'h0040_0120);
    cyc();
    n_checks++;
    if (bus.pc_src !== 1'b1 || bus.flush_ifid !== 1'b1 || bus.stall !== 1'b0 || bus.branch_target !== 32'h0040_0120) begin
      n_errors++; $display("FAIL beq_taken_same_cycle: got pc=%b fl=%b st=%b tgt=%h, want 1 1 0 00400120",
        bus.pc_src, bus.flush_ifid, bus.stall, bus.branch_target);
    end
    adv(); clr_all();
    cyc();
    n_checks++;
    if (bus.pc_src !== 1'b0 || bus.stall !== 1'b0 || bus.branch_target !== '0) begin
      n_errors++; $display("FAIL non_branch_idle: got pc=%b st=%b tgt=%h, want 0 0 0",
        bus.pc_src, bus.stall, bus.branch_target);
    end
    adv();
  endtask

  task automatic test_ex_alu();
    set_br(0, 1, 5, 9, 0, 32'h0000_2000);
    bus.ex_reg_write = 1; bus.ex_rd = 5'd5;
    cyc();
    n_checks++;
    if (bus.stall !== 1'b1 || bus.idex_bubble !== 1'b1 || bus.pc_src !== 1'b0) begin
      n_errors++; $display("FAIL bne_alu_stall: got st=%b bub=%b pc=%b, want 1 1 0",
        bus.stall, bus.idex_bubble, bus.pc_src);
    end
    adv();
    bus.ex_reg_write = 0; bus.ex_rd = '0;
    cyc();
    n_checks++;
    if (bus.pc_src !== 1'b1 || bus.flush_ifid !== 1'b1 || bus.stall !== 1'b0 || bus.branch_target !== 32'h0000_2000) begin
      n_errors++; $display("FAIL bne_alu_resolve: got pc=%b fl=%b st=%b tgt=%h, want 1 1 0 00002000",
        bus.pc_src, bus.flush_ifid, bus.stall, bus.branch_target);
    end
    adv(); clr_all();
  endtask

  task automatic test_load_use();
    set_br(1, 0, 2, 7, 1, 32'h0000_3000);
    bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_rd = 5'd7;
    for (int c = 0; c < 2; c++) begin
      cyc();
      n_checks++;
      if (bus.stall !== 1'b1 || bus.idex_bubble !== 1'b1 || bus.pc_src !== 1'b0) begin
        n_errors++; $display("FAIL load_use_stall%0d: got st=%b bub=%b pc=%b, want 1 1 0",
          c, bus.stall, bus.idex_bubble, bus.pc_src);
      end
      adv();
      bus.ex_mem_read = 0; bus.ex_reg_write = 0; bus.ex_rd = '0;
    end
    bus.cmp_equal = 0;
    cyc();
    n_checks++;
    if (bus.stall !== 1'b0 || bus.pc_src !== 1'b0 || bus.flush_ifid !== 1'b0) begin
      n_errors++; $display("FAIL load_use_not_taken: got st=%b pc=%b fl=%b, want 0 0 0",
        bus.stall, bus.pc_src, bus.flush_ifid);
    end
    adv(); clr_all();
  endtask

  task automatic test_r0();
    set_br(1, 0, 0, 2, 1, 32'h0000_4000);
    bus.ex_mem_read = 1; bus.ex_rd = 5'd0;
    cyc();
    n_checks++;
    if (bus.stall !== 1'b0 || bus.pc_src !== 1'b1) begin
      n_errors++; $display("FAIL r0_no_hazard: got st=%b pc=%b, want 0 1", bus.stall, bus.pc_src);
    end
    adv(); clr_all();
  endtask

  task automatic test_reset_mid_wait();
    set_br(1, 0, 2, 7, 1, 32'h0000_5000);
    bus.ex_mem_read = 1; bus.ex_rd = 5'd7;
    cyc(); adv();
    rst_n = 0;
    cyc();
    n_checks++;
    if ({bus.stall, bus.idex_bubble, bus.pc_src, bus.flush_ifid} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_mid_wait: got st/bub/pc/fl=%b%b%b%b, want 0000",
        bus.stall, bus.idex_bubble, bus.pc_src, bus.flush_ifid);
    end
    adv(); rst_n = 1; clr_all();
    cyc();
    n_checks++;
    if (bus.pc_src !== 1'b0 || bus.stall !== 1'b0) begin
      n_errors++; $display("FAIL reset_no_pulse: got pc=%b st=%b, want 0 0", bus.pc_src, bus.stall);
    end
    adv();
    set_br(1, 0, 3, 4, 1, 32'h0000_5100);
    cyc();
    n_checks++;
    if (bus.pc_src !== 1'b1 || bus.stall !== 1'b0) begin
      n_errors++; $display("FAIL reset_back_idle: got pc=%b st=%b, want 1 0", bus.pc_src, bus.stall);
    end
    adv(); clr_all();
  endtask

  task automatic test_hold();
    int stalls = 0;
    int guard = 0;
    bit done = 0;
    apply_reset();
    set_br(1, 0, 7, 4, 1, 32'h0000_6000);
    bus.ex_mem_read = 1; bus.ex_rd = 5'd7;
    cyc(); stalls += int'(bus.stall); adv();
    bus.ex_mem_read = 0; bus.ex_rd = '0;
    bus.pipe_hold = 1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_checks++;
      if (bus.stall !== 1'b0 || bus.pc_src !== 1'b0 || bus.flush_ifid !== 1'b0) begin
        n_errors++; $display("FAIL hold_forced_zero%0d: got st=%b pc=%b fl=%b, want 0 0 0",
          c, bus.stall, bus.pc_src, bus.flush_ifid);
      end
      adv();
    end
    bus.pipe_hold = 0;
    while (!done && guard < 8) begin
      cyc();
      stalls += int'(bus.stall);
      done = bus.pc_src;
      adv(); guard++;
    end
    n_checks++;
    if (!done || stalls != 2) begin
      n_errors++; $display("FAIL hold_stall_total: got stalls=%0d resolved=%b, want 2 1", stalls, done);
    end
    clr_all();
    cyc();
    n_checks++;
`ifdef BRANCH_STATS_EN
    if (bus.stat_stalls !== 32'd2 || bus.stat_branches !== 32'd1 || bus.stat_taken !== 32'd1) begin
      n_errors++; $display("FAIL hold_stats: got st=%0d br=%0d tk=%0d, want 2 1 1",
        bus.stat_stalls, bus.stat_branches, bus.stat_taken);
    end
`else
    if (bus.stat_stalls !== '0 || bus.stat_branches !== '0 || bus.stat_taken !== '0) begin
      n_errors++; $display("FAIL hold_stats_off: got st=%0d br=%0d tk=%0d, want 0 0 0",
        bus.stat_stalls, bus.stat_branches, bus.stat_taken);
    end
`endif
    adv();
  endtask

  task automatic test_flush();
    set_br(0, 1, 6, 1, 0, 32'h0000_7000);
    bus.ex_mem_read = 1; bus.ex_rd = 5'd6;
    cyc(); adv();
    clr_all();
    cyc();
    n_checks++;
    if (bus.pc_src !== 1'b0) begin
      n_errors++; $display("FAIL flush_no_resolve: got pc=%b, want 0", bus.pc_src);
    end
    adv();
    set_br(0, 1, 3, 4, 0, 32'h0000_7100);
    cyc();
    n_checks++;
    if (bus.pc_src !== 1'b1 || bus.stall !== 1'b0 || bus.branch_target !== 32'h0000_7100) begin
      n_errors++; $display("FAIL flush_then_idle: got pc=%b st=%b tgt=%h, want 1 0 00007100",
        bus.pc_src, bus.stall, bus.branch_target);
    end
    adv(); clr_all();
  endtask

  task automatic test_random();
    bit typ = 0;
    bit br_on;
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bus.pipe_hold = ($urandom_range(0, 5) == 0);
      br_on = m_busy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 6);
      if (!m_busy) begin
        typ = 1'($urandom_range(0, 1));
        bus.id_rs = RW'($urandom_range(0, 7));
        bus.id_rt = RW'($urandom_range(0, 7));
        bus.id_target = {$urandom(), 2'b00} ;
      end
      bus.id_beq = br_on & ~typ; bus.id_bne = br_on & typ;
      bus.cmp_equal = 1'($urandom_range(0, 1));
      bus.ex_reg_write = 1'($urandom_range(0, 1));
      bus.ex_mem_read = 1'($urandom_range(0, 1));
      bus.ex_rd = RW'($urandom_range(0, 7));
      bus.mem_mem_read = 1'($urandom_range(0, 1));
      bus.mem_rd = RW'($urandom_range(0, 7));
      cyc();
      n_checks++;
      if (bus.stall !== e_stall || bus.pc_src !== e_pc || bus.flush_ifid !== e_pc || bus.branch_target !== e_tgt) begin
        n_errors++; $display("FAIL rand_outputs[%0d]: got st=%b pc=%b fl=%b tgt=%h, want %b %b %b %h",
          i, bus.stall, bus.pc_src, bus.flush_ifid, bus.branch_target, e_stall, e_pc, e_pc, e_tgt);
      end
      if (!bus.pipe_hold) begin
        n_checks++;
        if (bus.idex_bubble !== e_stall) begin
          n_errors++; $display("FAIL rand_bubble[%0d]: got %b, want %b", i, bus.idex_bubble, e_stall);
        end
      end
      n_checks++;
      if (bus.stat_branches !== e_nb || bus.stat_taken !== e_nt || bus.stat_stalls !== e_ns) begin
        n_errors++; $display("FAIL rand_stats[%0d]: got %0d/%0d/%0d, want %0d/%0d/%0d",
          i, bus.stat_branches, bus.stat_taken, bus.stat_stalls, e_nb, e_nt, e_ns);
      end
      adv();
    end
    rst_n = 1; clr_all();
  endtask

  initial begin
    clr_all();
    test_reset();
    test_no_hazard();
    test_ex_alu();
    test_load_use();
    test_r0();
    test_reset_mid_wait();
    test_hold();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
